// File: rtl/iir_par_sched.sv
// rtl/iir_par_sched.sv - round-robin scheduler sharing one polyphase IIR engine among NCH channels
// Optional: define IIR_PAR_SCHED_PRIO_EN to give channel 0 strict priority.
module iir_par_sched #(
  parameter int NCH = 4,
  parameter int CW  = 2,
  parameter int W   = 14,
  parameter int LAT = 3,
  parameter int TMO = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*(W+1)-1:0] x_flat,
  output logic [NCH-1:0]       gnt,
  output logic                 eng_start,
  output logic [W:0]           eng_x,
  output logic [CW-1:0]        eng_ch,
  output logic                 eng_phase,
  input  logic                 eng_done,
  input  logic [W:0]           eng_y,
  output logic                 y_vld,
  output logic [W:0]           y_out,
  output logic [CW-1:0]        y_ch,
  output logic                 busy,
  output logic                 err
);

  localparam int CNTW = $clog2(LAT + TMO + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RET} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   ptr, ptr_nx, pick;
  logic [NCH-1:0]  phase;
  logic [CNTW-1:0] cnt;
  logic            timeout;
  int              idx;

  // eng_ch doubles as the channel of the transaction in flight
  always_comb begin
    pick = '0;
    idx  = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NCH;
      if (req[idx]) pick = CW'(idx);
    end
`ifdef IIR_PAR_SCHED_PRIO_EN
    if (req[0]) pick = '0;
`endif
  end

  always_comb begin
    ptr_nx = (int'(eng_ch) == NCH - 1) ? '0 : eng_ch + 1'b1;
`ifdef IIR_PAR_SCHED_PRIO_EN
    if (eng_ch == '0) ptr_nx = ptr;
`endif
  end

  always_comb begin
    state_nx  = state;
    timeout   = 1'b0;
    gnt       = '0;
    eng_start = 1'b0;
    y_vld     = 1'b0;
    busy      = (state != IDLE);
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (|req) state_nx = ISSUE;
        err = eng_done;
      end
      ISSUE: begin
        gnt       = {{(NCH-1){1'b0}}, 1'b1} << eng_ch;
        eng_start = 1'b1;
        err       = eng_done;
        state_nx  = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          state_nx = RET;
        end else if (cnt == CNTW'(LAT + TMO - 1)) begin
          timeout  = 1'b1;
          err      = 1'b1;
          state_nx = IDLE;
        end
      end
      RET: begin
        y_vld    = 1'b1;
        err      = eng_done;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      phase     <= '0;
      cnt       <= '0;
      eng_x     <= '0;
      eng_ch    <= '0;
      eng_phase <= 1'b0;
      y_out     <= '0;
      y_ch      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (|req) begin
            eng_x     <= x_flat[int'(pick)*(W+1) +: W+1];
            eng_ch    <= pick;
            eng_phase <= phase[pick];
          end
        end
        ISSUE: begin
          phase[eng_ch] <= ~phase[eng_ch];
          cnt           <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (eng_done) begin
            y_out <= eng_y;
            y_ch  <= eng_ch;
          end else if (timeout) begin
            ptr <= ptr_nx;
          end
        end
        RET: ptr <= ptr_nx;
        default: ;
      endcase
    end
  end

endmodule
